lsu: RTL

- Load/store unit directly downstream of the execute stage.
- Takes the single-cycle memory write request and the load address produced by execute, and runs a multi-cycle req/gnt/rvalid transaction on the data bus.
- Stalls the pipeline through the hold path to ctrl while the transaction is outstanding.
- Returns the raw 32-bit read word to execute, which does the byte/half extraction.

---
 rtl/lsu.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: turns a single-cycle store or load request from execute
// into one req/gnt/rvalid data-bus transaction and stalls the pipeline
// through hold_flag_o until the access finishes or is aborted by timeout.
//
// Handshake: bus_req_o and the latched command fields stay stable from the
// first REQ cycle until a cycle where bus_gnt_i is high; that cycle is the
// transfer. For reads, bus_rvalid_i/bus_rdata_i are sampled only in WAIT_R,
// which starts the cycle after the grant.
module lsu #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr_req_i,
    input  logic [3:0]        mem_wr_sel_i,
    input  logic [31:0]       mem_wr_addr_i,
    input  logic [31:0]       mem_wr_data_i,
    input  logic              mem_rd_req_i,
    input  logic [31:0]       mem_rd_addr_i,
    output logic [31:0]       mem_rd_data_o,
    output logic              mem_rd_valid_o,
    output logic              hold_flag_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        at_limit;
    logic        abort;
    logic        hold;
    logic        req_any;
    logic [31:0] sel_addr;

    assign req_any   = mem_wr_req_i | mem_rd_req_i;
    assign at_limit  = (cnt == 8'(TIMEOUT - 1));
    // The write wins when both requests are present.
    assign sel_addr  = mem_wr_req_i ? mem_wr_addr_i : mem_rd_addr_i;
    // Reset forces the stall off even though the request may still be high.
    assign hold_flag_o = hold & ~rst;
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, stall request and timeout abort decision.
    always_comb begin
        state_next = state;
        hold       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    hold       = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                hold = 1'b1;
                // A grant completes a write; a read still needs rvalid, so a
                // grant in the last allowed cycle does not save a read.
                if (bus_we_o && bus_gnt_i) begin
                    state_next = DONE;
                end else if (at_limit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end else if (bus_gnt_i) begin
                    state_next = WAIT_R;
                end
            end
            WAIT_R: begin
                hold = 1'b1;
                if (bus_rvalid_i) begin
                    state_next = DONE;
                end else if (at_limit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Cycles spent in REQ+WAIT_R; zero whenever outside those states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (state == REQ || state == WAIT_R) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    // Bus command latch, read-data capture and one-cycle DONE strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_data_o  <= 32'd0;
            mem_rd_valid_o <= 1'b0;
            err_o          <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= '0;
            bus_sel_o      <= 4'd0;
            bus_wdata_o    <= 32'd0;
        end else begin
            mem_rd_valid_o <= 1'b0;
            err_o          <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_wr_req_i;
                        bus_addr_o  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_o   <= mem_wr_req_i ? mem_wr_sel_i : 4'b1111;
                        bus_wdata_o <= mem_wr_data_i;
                    end
                end
                REQ: begin
                    if (abort) begin
                        bus_req_o     <= 1'b0;
                        mem_rd_data_o <= 32'd0;
                        err_o         <= 1'b1;
                    end else if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid_i) begin
                        mem_rd_data_o  <= bus_rdata_i;
                        mem_rd_valid_o <= 1'b1;
                    end else if (abort) begin
                        mem_rd_data_o <= 32'd0;
                        err_o         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
